// File: rtl/show_char_pkg.sv
// Shared types and defaults for the character-layer sprite arbiter.
package show_char_pkg;

  localparam int N_CHAR_DEF = 5;
  localparam int MAP_W_DEF  = 288;
  localparam int CHAR_SIZE  = 16;
  localparam int PART_SIZE  = 8;

  typedef enum logic [2:0] {
    PACMAN = 3'd0,
    BLINKY = 3'd1,
    PINKY  = 3'd2,
    INKY   = 3'd3,
    CLYDE  = 3'd4
  } char_id_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } sched_state_e;

endpackage

// File: rtl/char_hit.sv
// Combinational 16x16 hit test of one pixel against one character.
// CHAR_TUNNEL_WRAP_EN adds a same-cycle retest at x + MAP_W for tunnel wrap.
module char_hit
  import show_char_pkg::*;
#(
  parameter int CW    = 10,
  parameter int MAP_W = MAP_W_DEF
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] cx,
  input  logic [CW-1:0] cy,
  output logic          hit,
  output logic [1:0]    part,
  output logic [5:0]    offset
);

  localparam int EW = CW + 1;

`ifdef CHAR_TUNNEL_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic [EW-1:0] x_e, y_e, cx_e, cy_e, x_w;
  logic [EW-1:0] dx_d, dx_w, dx, dy;
  logic          hit_y, hit_dx, hit_wx;

  always_comb begin
    // One extra bit keeps cx + CHAR_SIZE from overflowing near the map edge.
    x_e  = {1'b0, x};
    y_e  = {1'b0, y};
    cx_e = {1'b0, cx};
    cy_e = {1'b0, cy};
    x_w  = x_e + EW'(MAP_W);

    hit_y  = (y_e >= cy_e) && (y_e < cy_e + EW'(CHAR_SIZE));
    hit_dx = (x_e >= cx_e) && (x_e < cx_e + EW'(CHAR_SIZE));
    hit_wx = WRAP_EN && (x_w >= cx_e) && (x_w < cx_e + EW'(CHAR_SIZE));

    dx_d = x_e - cx_e;
    dx_w = x_w - cx_e;
    dx   = hit_dx ? dx_d : dx_w;
    dy   = y_e - cy_e;

    hit    = hit_y && (hit_dx || hit_wx);
    part   = {dy >= EW'(PART_SIZE), dx >= EW'(PART_SIZE)};
    offset = {dx[2:0], dy[2:0]};
  end

endmodule

// File: rtl/char_scheduler.sv
// Per-pixel sprite arbiter: scans a snapshot of all characters through one
// shared char_hit unit in priority order. Optional macro: CHAR_TUNNEL_WRAP_EN.
module char_scheduler
  import show_char_pkg::*;
#(
  parameter int N_CHAR = N_CHAR_DEF,
  parameter int MAP_W  = MAP_W_DEF,
  parameter int CW     = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [CW-1:0]        i_x_cord,
  input  logic [CW-1:0]        i_y_cord,
  input  logic [N_CHAR*CW-1:0] i_char_x,
  input  logic [N_CHAR*CW-1:0] i_char_y,
  input  logic [N_CHAR-1:0]    i_char_en,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic                 o_hit,
  output logic [2:0]           o_char_id,
  output logic [1:0]           o_part_offset,
  output logic [5:0]           o_char_offset,
  output logic                 o_busy
);

  localparam int KW = (N_CHAR > 1) ? $clog2(N_CHAR) : 1;

  sched_state_e        state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic                snap_load;

  logic [CW-1:0]        x_q, y_q;
  logic [N_CHAR*CW-1:0] char_x_q, char_y_q;
  logic [N_CHAR-1:0]    char_en_q;

  logic [CW-1:0] cur_cx, cur_cy;
  logic          cur_en;
  logic          unit_hit;
  logic [1:0]    unit_part;
  logic [5:0]    unit_off;

  logic       hit_q, hit_d;
  logic [2:0] id_q, id_d;
  logic [1:0] part_q, part_d;
  logic [5:0] off_q, off_d;

  always_comb begin
    cur_cx = char_x_q[k_q*CW +: CW];
    cur_cy = char_y_q[k_q*CW +: CW];
    cur_en = char_en_q[k_q];
  end

  char_hit #(
    .CW    (CW),
    .MAP_W (MAP_W)
  ) u_hit (
    .x      (x_q),
    .y      (y_q),
    .cx     (cur_cx),
    .cy     (cur_cy),
    .hit    (unit_hit),
    .part   (unit_part),
    .offset (unit_off)
  );

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d   = state_q;
    k_d       = k_q;
    snap_load = 1'b0;
    hit_d     = hit_q;
    id_d      = id_q;
    part_d    = part_q;
    off_d     = off_q;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          snap_load = 1'b1;
          k_d       = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (cur_en && unit_hit) begin
          hit_d   = 1'b1;
          id_d    = 3'(k_q);
          part_d  = unit_part;
          off_d   = unit_off;
          state_d = RESP;
        end else if (k_q == KW'(N_CHAR - 1)) begin
          hit_d   = 1'b0;
          id_d    = '0;
          part_d  = '0;
          off_d   = '0;
          state_d = RESP;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      hit_q   <= 1'b0;
      id_q    <= '0;
      part_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      hit_q   <= hit_d;
      id_q    <= id_d;
      part_q  <= part_d;
      off_q   <= off_d;
    end
  end

  // NOTE: the snapshot is pure datapath, always loaded before use, so it has no reset.
  always_ff @(posedge i_clk) begin
    if (snap_load) begin
      x_q       <= i_x_cord;
      y_q       <= i_y_cord;
      char_x_q  <= i_char_x;
      char_y_q  <= i_char_y;
      char_en_q <= i_char_en;
    end
  end

  // Gating with i_rst keeps a discarded request from handshaking during reset.
  assign o_req_ready   = (state_q == IDLE) && !i_rst;
  assign o_rsp_valid   = (state_q == RESP) && !i_rst;
  assign o_busy        = (state_q != IDLE);
  assign o_hit         = hit_q;
  assign o_char_id     = id_q;
  assign o_part_offset = part_q;
  assign o_char_offset = off_q;

endmodule

// File: tb/tb_char_scheduler.sv
// Scoreboard bench for char_scheduler: expected responses are queued at the
// request handshake and compared, with latency, when o_rsp_valid appears.
module tb_char_scheduler;
  import show_char_pkg::*;

  localparam int N  = 5;
  localparam int CW = 10;
  localparam int MISS_LAT = N + 1;

  typedef struct {
    logic       hit;
    logic [2:0] id;
    logic [1:0] part;
    logic [5:0] off;
    int         lat;
  } exp_t;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_req_valid = 1'b0;
  logic            o_req_ready;
  logic [CW-1:0]   i_x_cord = '0;
  logic [CW-1:0]   i_y_cord = '0;
  logic [N*CW-1:0] i_char_x = '0;
  logic [N*CW-1:0] i_char_y = '0;
  logic [N-1:0]    i_char_en = '0;
  logic            o_rsp_valid;
  logic            i_rsp_ready = 1'b0;
  logic            o_hit;
  logic [2:0]      o_char_id;
  logic [1:0]      o_part_offset;
  logic [5:0]      o_char_offset;
  logic            o_busy;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  char_scheduler #(.N_CHAR(N), .MAP_W(288), .CW(CW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_x_cord      (i_x_cord),
    .i_y_cord      (i_y_cord),
    .i_char_x      (i_char_x),
    .i_char_y      (i_char_y),
    .i_char_en     (i_char_en),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_hit         (o_hit),
    .o_char_id     (o_char_id),
    .o_part_offset (o_part_offset),
    .o_char_offset (o_char_offset),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic hit, input logic [2:0] id, input logic [1:0] part,
                              input logic [5:0] off, input int lat);
    exp_t e;
    e.hit = hit; e.id = id; e.part = part; e.off = off; e.lat = lat;
    return e;
  endfunction

  task automatic set_char(input int i, input int x, input int y);
    i_char_x[i*CW +: CW] = CW'(x);
    i_char_y[i*CW +: CW] = CW'(y);
  endtask

  task automatic park_all();
    for (int i = 0; i < N; i++) set_char(i, 600, 600);
    i_char_en = '1;
  endtask

  task automatic run_req(input string tag, input int x, input int y, input exp_t e, input int hold);
    exp_t want;
    int   lat;
    bit   seen;
    @(negedge i_clk);
    i_x_cord    = CW'(x);
    i_y_cord    = CW'(y);
    i_req_valid = 1'b1;
    i_rsp_ready = (hold == 0);
    check({tag, "_req_ready"}, o_req_ready, 1);
    @(posedge i_clk);
    sb_q.push_back(e);
    #1;
    // Scramble live inputs: only the snapshot may influence the result.
    i_req_valid = 1'b0;
    i_x_cord    = CW'($urandom);
    i_y_cord    = CW'($urandom);
    i_char_x    = ~i_char_x;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      if (c == 1) check({tag, "_busy_ready"}, {o_busy, o_req_ready}, 2'b10);
      if (o_rsp_valid) begin
        seen = 1'b1;
        lat  = c;
        break;
      end
    end
    want = sb_q.pop_front();
    i_char_x = ~i_char_x;
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
      i_rsp_ready = 1'b1;
      return;
    end
    check({tag, "_lat"}, lat, want.lat);
    check({tag, "_hit"}, o_hit, want.hit);
    check({tag, "_id"}, o_char_id, want.id);
    check({tag, "_part"}, o_part_offset, want.part);
    check({tag, "_off"}, o_char_offset, want.off);
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      check({tag, "_hold"}, {o_rsp_valid, o_hit, o_char_id, o_part_offset, o_char_offset},
            {1'b1, want.hit, want.id, want.part, want.off});
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    check({tag, "_idle_after"}, {o_rsp_valid, o_busy, o_req_ready}, 3'b001);
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    int vcount;
    park_all();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_req_ready_low", o_req_ready, 0);
    check("rst_outputs", {o_rsp_valid, o_hit, o_char_id, o_part_offset, o_char_offset, o_busy}, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_rst_req_ready", o_req_ready, 1);

    park_all();
    set_char(0, 100, 50);
    run_req("t1_pacman", 109, 53, mk(1, PACMAN, 1, 11, 2), 0);

    park_all();
    set_char(0, 20, 20);
    set_char(3, 20, 20);
    i_char_en = 5'b01000;
    run_req("t2_inky", 27, 35, mk(1, INKY, 2, 63, 5), 0);

    park_all();
    set_char(1, 35, 35);
    set_char(4, 30, 30);
    run_req("t3_prio", 40, 40, mk(1, BLINKY, 0, 45, 3), 0);
    i_char_en[1] = 1'b0;
    run_req("t3_prio_dis", 40, 40, mk(1, CLYDE, 3, 18, 6), 0);

    park_all();
    run_req("t4_miss_hold", 0, 0, mk(0, 0, 0, 0, MISS_LAT), 3);

    park_all();
    set_char(2, 200, 100);
    run_req("t5_edge_in", 215, 115, mk(1, PINKY, 3, 63, 4), 0);
    run_req("t5_edge_x16", 216, 100, mk(0, 0, 0, 0, MISS_LAT), 0);
    run_req("t5_edge_left", 199, 100, mk(0, 0, 0, 0, MISS_LAT), 0);
    run_req("t5_edge_y16", 200, 116, mk(0, 0, 0, 0, MISS_LAT), 0);

    park_all();
    set_char(0, 280, 10);
`ifdef CHAR_TUNNEL_WRAP_EN
    run_req("t6_wrap", 3, 12, mk(1, PACMAN, 1, 26, 2), 0);
`else
    run_req("t6_wrap", 3, 12, mk(0, 0, 0, 0, MISS_LAT), 0);
`endif

    // Reset while character 2 is under test.
    park_all();
    @(negedge i_clk);
    i_x_cord = '0; i_y_cord = '0; i_req_valid = 1'b1; i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    check("t7_busy_scan", o_busy, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("t7_rst_no_rsp", {o_rsp_valid, o_req_ready}, 2'b00);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("t7_ready_after", o_req_ready, 1);
    check("t7_outputs", {o_rsp_valid, o_hit, o_char_id, o_part_offset, o_char_offset, o_busy}, 0);
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      if (o_rsp_valid) vcount++;
    end
    check("t7_no_late_rsp", vcount, 0);
    i_rsp_ready = 1'b0;

    set_char(0, 100, 50);
    run_req("t8_resume", 109, 53, mk(1, PACMAN, 1, 11, 2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/char_scheduler.md
# char_scheduler

Per-pixel sprite arbiter for the character layer. It accepts one screen coordinate per request and scans all characters (Pac-Man plus four ghosts) through a single shared hit-test unit, one character per cycle, in priority order. It returns the winning character, its 8×8 quadrant and the pixel offset inside that quadrant. It sits between the pixel renderer (requester) and the sprite ROM address logic (consumer).

## Interface
- `N_CHAR`, 5: number of characters scanned. Index 0 is the highest priority.
- `MAP_W`, 288: map width in pixels. Used only for tunnel wrap.
- `CW`, 10: coordinate width.
- `i_clk`  in  1: clock.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_req_valid`  in  1: request valid.
- `o_req_ready`  out  1: request accepted when high together with `i_req_valid`.
- `i_x_cord`, `i_y_cord`  in  CW each: pixel coordinate to test.
- `i_char_x`, `i_char_y`  in  N_CHAR*CW each: top-left corner of each character. Character i occupies bits [i*CW +: CW].
- `i_char_en`  in  N_CHAR: character visible.
- `o_rsp_valid`  out  1: response valid.
- `i_rsp_ready`  in  1: response consumed.
- `o_hit`  out  1: some enabled character covers the pixel.
- `o_char_id`  out  3: index of the winning character.
- `o_part_offset`  out  2: quadrant of the winning character. 0 = top-left, 1 = top-right, 2 = bottom-left, 3 = bottom-right.
- `o_char_offset`  out  6: pixel within the quadrant, computed as x_off*8 + y_off.
- `o_busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, SCAN, RESP.
- **IDLE:** `o_req_ready`=1. On request handshake:
  - Latch the coordinate, all `i_char_x`/`i_char_y`/`i_char_en` (a snapshot, so there is no tearing mid-scan).
  - Set index k=0 and go to SCAN.
- **SCAN:** each cycle, test character k with the shared hit unit.
  - k enabled and hit: register id=k, part and offset; set `o_hit`=1; go to RESP.
  - Otherwise: if k==N_CHAR-1, go to RESP with `o_hit`=0, id=0, part=0, offset=0. Else k++.
  - Disabled characters still consume their cycle.
- **RESP:** hold `o_rsp_valid`=1 with stable outputs until `i_rsp_ready`, then go to IDLE. `o_req_ready`=0 in both SCAN and RESP.
- **Hit test** for character (cx,cy):
  - dx = x−cx, dy = y−cy.
  - Hit when 0≤dx<16 and 0≤dy<16.
  - part = {dy≥8, dx≥8}.
  - x_off = dx[2:0], y_off = dy[2:0].
- **Arithmetic:** compares use CW+1 bits (zero-extended), so cx+16 never overflows.
- **Priority:** when characters overlap, the lowest index wins.

## Timing
- Handshake accepted in cycle T. Character k is tested in cycle T+1+k.
- Hit at index k: `o_rsp_valid` rises at T+2+k.
- Miss: `o_rsp_valid` rises at T+1+N_CHAR (T+6 with the default).
- After the response handshake, the FSM is in IDLE the next cycle. Minimum request spacing is k+3 cycles.
- `i_rsp_ready` held high in RESP: the response lasts exactly one cycle.
- **Reset values:**
  - state IDLE, k=0.
  - `o_req_ready`=0 while `i_rst` is high, 1 on the first cycle after.
  - `o_rsp_valid`=0, `o_hit`=0, `o_char_id`=0, `o_part_offset`=0, `o_char_offset`=0, `o_busy`=0.
- **Reset mid-scan or mid-response:** the request is discarded; no response is emitted.
- Request inputs change while busy: ignored; only the snapshot is used.

## Configuration
- Macro: `CHAR_TUNNEL_WRAP_EN`.
- **Defined:** a character with cx > MAP_W−16 also covers columns 0..cx+15−MAP_W.
  - When the direct test misses, the hit unit retests with x' = x+MAP_W.
  - Part and offset are computed from x'. Both tests happen in the same SCAN cycle.
- **Undefined:** direct test only. Pixels past the map edge are never hit through wrap.

## Structure
- **Package `show_char_pkg`:**
  - `N_CHAR_DEF`, `MAP_W_DEF`, `CHAR_SIZE`=16, `PART_SIZE`=8.
  - Enum `char_id_e`: PACMAN=0, BLINKY, PINKY, INKY, CLYDE.
  - Enum `sched_state_e`: IDLE, SCAN, RESP.
- **Sub-module `char_hit`:** purely combinational.
  - Inputs: coordinate, cx, cy.
  - Outputs: hit, part, offset.
  - Owns the wrap retest under the macro.
  - Instantiated once.

## Test plan
- Char 0 at (100,50), all enabled, request (109,53) → response at T+2: hit=1, id=0, part=1, offset=1*8+3=11.
- Only char 3 enabled at (20,20), request (27,35) → response at T+5: id=3, part=2, offset=7*8+7=63.
- Char 1 and char 4 both cover (40,40) → id=1. Clear `i_char_en[1]` → id=4.
- No character covers (0,0) → response at T+6, hit=0, all fields 0. Hold `i_rsp_ready`=0 for 3 cycles → outputs stable; handshake → IDLE next cycle.
- Char 0 at (280,10), request (3,12):
  - With `CHAR_TUNNEL_WRAP_EN`: hit, part=1, offset=3*8+2=26.
  - Without it: miss.
- Assert `i_rst` during SCAN at index 2 → no `o_rsp_valid`, all outputs at reset values, `o_req_ready`=1 the cycle after reset deasserts.
